// File: rtl/div16_seq_pkg.sv
// Shared definitions for the sequential 16-bit divider: operand width,
// iteration-counter width and the FSM state encoding.
package div16_seq_pkg;

  localparam int DIV_WIDTH = 16;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/div16_seq_div_step.sv
// One restoring radix-2 step: shift {R,Q} left, trial-subtract the divisor
// magnitude, keep the difference and set the quotient bit when nothing borrowed.
module div16_seq_div_step
  import div16_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] r_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] r_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             borrow;

  // The extra top bit of the trial difference is the borrow out of the subtraction.
  always_comb begin
    shifted = {r_i, q_i[WIDTH-1]};
    trial   = {1'b0, shifted} - {2'b00, d_i};
    borrow  = trial[WIDTH+1];
    r_o     = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    q_o     = {q_i[WIDTH-2:0], ~borrow};
  end

endmodule

// File: rtl/div16_seq.sv
// Multi-cycle restoring divider with start/done handshake, signed or unsigned
// per operation; the core stalls its EX stage while busy_o is high.
module div16_seq
  import div16_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             sgn_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             dbz_o
);

  localparam int CNT_W = $clog2(WIDTH);

  state_e           state_q;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] partRem_q;
  logic [WIDTH-1:0] quoBits_q;
  logic [WIDTH-1:0] dvsrMag_q;
  logic             qNeg_q;
  logic             rNeg_q;
  logic             zeroDiv_q;
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;

  logic [WIDTH-1:0] partRem_d;
  logic [WIDTH-1:0] quoBits_d;

  logic             dvdNeg;
  logic             dvsNeg;
  logic [WIDTH-1:0] dvdMag;
  logic [WIDTH-1:0] dvsMag;

  always_comb begin
    dvdNeg = sgn_i & dividend_i[WIDTH-1];
    dvsNeg = sgn_i & divisor_i[WIDTH-1];
    dvdMag = dvdNeg ? (~dividend_i) + WIDTH'(1) : dividend_i;
    dvsMag = dvsNeg ? (~divisor_i) + WIDTH'(1) : divisor_i;
  end

  div16_seq_div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .r_i (partRem_q),
    .q_i (quoBits_q),
    .d_i (dvsrMag_q),
    .r_o (partRem_d),
    .q_o (quoBits_d)
  );

  // On divide-by-zero the raw dividend rides in quoBits_q so FIX can return it untouched.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      count_q     <= '0;
      partRem_q   <= '0;
      quoBits_q   <= '0;
      dvsrMag_q   <= '0;
      qNeg_q      <= 1'b0;
      rNeg_q      <= 1'b0;
      zeroDiv_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            busy_q    <= 1'b1;
            dbz_q     <= 1'b0;
            partRem_q <= '0;
            count_q   <= CNT_W'(WIDTH - 1);
            qNeg_q    <= dvdNeg ^ dvsNeg;
            rNeg_q    <= dvdNeg;
            dvsrMag_q <= dvsMag;
            if (divisor_i == '0) begin
              zeroDiv_q <= 1'b1;
              quoBits_q <= dividend_i;
              state_q   <= FIX;
            end else begin
              zeroDiv_q <= 1'b0;
              quoBits_q <= dvdMag;
              state_q   <= RUN;
            end
          end
        end
        RUN: begin
          partRem_q <= partRem_d;
          quoBits_q <= quoBits_d;
          count_q   <= count_q - CNT_W'(1);
          if (count_q == '0) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          if (zeroDiv_q) begin
            quotient_q  <= '1;
            remainder_q <= quoBits_q;
            dbz_q       <= 1'b1;
          end else begin
            quotient_q  <= qNeg_q ? (~quoBits_q) + WIDTH'(1) : quoBits_q;
            remainder_q <= rNeg_q ? (~partRem_q) + WIDTH'(1) : partRem_q;
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign quotient_o  = quotient_q;
  assign remainder_o = remainder_q;
  assign dbz_o       = dbz_q;

endmodule

// File: tb/tb_div16_seq.sv
// Self-checking bench for div16_seq: directed vector table, multi-cycle corner
// sequences and randomized operations against an arithmetic reference model.
module tb_div16_seq;

  localparam int W = 16;
  localparam int LAT_RUN = W + 1;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         start_i;
  logic         sgn_i;
  logic [W-1:0] dividend_i;
  logic [W-1:0] divisor_i;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] quotient_o;
  logic [W-1:0] remainder_o;
  logic         dbz_o;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] prevQ;
  logic [W-1:0] prevR;

  typedef struct {
    logic         s;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           lat;
  } vec_t;

  vec_t vecs[10];

  div16_seq dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .sgn_i       (sgn_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .quotient_o  (quotient_o),
    .remainder_o (remainder_o),
    .dbz_o       (dbz_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Truncating division from plain integer arithmetic; remainder follows the dividend sign.
  function automatic void refModel(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] q, output logic [W-1:0] r,
                                   output logic z, output int lat);
    int sa;
    int sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (b == '0) begin
      q = '1;
      r = a;
      z = 1'b1;
      lat = 1;
    end else begin
      z = 1'b0;
      lat = LAT_RUN;
      if (!s) begin
        q = a / b;
        r = a % b;
      end else if (sa == -32768 && sb == -1) begin
        q = 16'h8000;
        r = 16'h0000;
      end else begin
        q = W'(sa / sb);
        r = W'(sa % sb);
      end
    end
  endfunction

  // Starts immediately (so a call right after a done cycle is a back-to-back start),
  // optionally pulses a junk start while busy, then waits for done within a bounded budget.
  task automatic applyStimulus(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] expQ, input logic [W-1:0] expR,
                               input logic expZ, input int expLat, input int injectAt,
                               input string tag);
    logic ok;
    logic got;
    int   lat;
    ok  = 1'b1;
    got = 1'b0;
    lat = 0;
    start_i    = 1'b1;
    sgn_i      = s;
    dividend_i = a;
    divisor_i  = b;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    if (dbz_o !== 1'b0 || busy_o !== 1'b1 || done_o !== 1'b0 ||
        quotient_o !== prevQ || remainder_o !== prevR) ok = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (k == injectAt) begin
        start_i    = 1'b1;
        sgn_i      = ~s;
        dividend_i = 16'h1234;
        divisor_i  = 16'h0003;
      end
      @(posedge clk_i); #1;
      start_i = 1'b0;
      if (done_o === 1'b1) begin
        lat = k;
        got = 1'b1;
        break;
      end
      if (busy_o !== 1'b1) ok = 1'b0;
    end
    checkOutput({tag, "_done_seen"}, 32'(got), 32'd1);
    if (got) begin
      if (busy_o !== 1'b0) ok = 1'b0;
      checkOutput({tag, "_latency"}, 32'(lat), 32'(expLat));
      checkOutput({tag, "_quotient"}, 32'(quotient_o), 32'(expQ));
      checkOutput({tag, "_remainder"}, 32'(remainder_o), 32'(expR));
      checkOutput({tag, "_dbz"}, 32'(dbz_o), 32'(expZ));
      checkOutput({tag, "_busy_profile"}, 32'(ok), 32'd1);
    end
    prevQ = expQ;
    prevR = expR;
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [W-1:0] mq;
    logic [W-1:0] mr;
    logic         mz;
    int           mlat;
    logic         rs;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         doneSeen;

    vecs[0] = '{1'b0, 16'd100,  16'd7,    16'd14,   16'd2,    1'b0, LAT_RUN};
    vecs[1] = '{1'b1, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, LAT_RUN};
    vecs[2] = '{1'b1, 16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0, LAT_RUN};
    vecs[3] = '{1'b0, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1};
    vecs[4] = '{1'b1, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1};
    vecs[5] = '{1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, LAT_RUN};
    vecs[6] = '{1'b0, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, LAT_RUN};
    vecs[7] = '{1'b0, 16'h0005, 16'h0009, 16'h0000, 16'h0005, 1'b0, LAT_RUN};
    vecs[8] = '{1'b1, 16'h8000, 16'h0002, 16'hC000, 16'h0000, 1'b0, LAT_RUN};
    vecs[9] = '{1'b0, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, LAT_RUN};

    rst_ni     = 1'b0;
    start_i    = 1'b0;
    sgn_i      = 1'b0;
    dividend_i = '0;
    divisor_i  = '0;
    prevQ      = '0;
    prevR      = '0;
    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("reset_busy", 32'(busy_o), 32'd0);
    checkOutput("reset_done", 32'(done_o), 32'd0);
    checkOutput("reset_quotient", 32'(quotient_o), 32'd0);
    checkOutput("reset_remainder", 32'(remainder_o), 32'd0);
    checkOutput("reset_dbz", 32'(dbz_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z,
                    vecs[i].lat, 0, $sformatf("vec%0d", i));
    end

    // A start pulse at T+5 with different operands must be ignored while busy.
    applyStimulus(1'b0, 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, LAT_RUN, 5, "busy_start");

    // Reset in the middle of RUN clears everything at once and suppresses done.
    start_i    = 1'b1;
    sgn_i      = 1'b0;
    dividend_i = 16'hABCD;
    divisor_i  = 16'h0013;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (7) @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    checkOutput("midrst_busy", 32'(busy_o), 32'd0);
    checkOutput("midrst_done", 32'(done_o), 32'd0);
    checkOutput("midrst_quotient", 32'(quotient_o), 32'd0);
    checkOutput("midrst_remainder", 32'(remainder_o), 32'd0);
    checkOutput("midrst_dbz", 32'(dbz_o), 32'd0);
    doneSeen = 1'b0;
    repeat (3) begin
      @(posedge clk_i); #1;
      if (done_o !== 1'b0) doneSeen = 1'b1;
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk_i); #1;
      if (done_o !== 1'b0 || busy_o !== 1'b0) doneSeen = 1'b1;
    end
    checkOutput("midrst_no_done", 32'(doneSeen), 32'd0);
    prevQ = '0;
    prevR = '0;
    refModel(1'b1, 16'hFF9C, 16'h0007, mq, mr, mz, mlat);
    applyStimulus(1'b1, 16'hFF9C, 16'h0007, mq, mr, mz, mlat, 0, "after_reset");

    for (int i = 0; i < 60; i++) begin
      rs = 1'(($urandom) & 1);
      ra = W'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1:       rb = W'($urandom_range(1, 15));
        2:       rb = '1;
        default: rb = W'($urandom);
      endcase
      refModel(rs, ra, rb, mq, mr, mz, mlat);
      applyStimulus(rs, ra, rb, mq, mr, mz, mlat, 0, $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
